pipe_ctrl_regs: RTL and testbench
=================================

Name: pipe_ctrl_regs

Overview:
Pipeline control-register bank for the 5-stage ARM core. It carries decoded control and register-address fields from Fetch through Writeback, and obeys the stall/flush commands issued by the hazard unit. It produces the per-stage address and write-enable signals that the hazard unit compares for forwarding and load-use detection. In short, it is the executing end of the hazard command interface.

Parameters:
INSTR_W, 32, fetched instruction width
PC_W, 32, program counter width
RA_W, 4, register-address width (R0-R15)

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
StallF  in  1  hold PCF
StallD  in  1  hold Decode register
FlushD  in  1  clear Decode register to bubble
FlushE  in  1  clear Execute register to bubble
PCNextF  in  PC_W  next PC from PC mux
InstrF  in  INSTR_W  fetched instruction
PCF  out  PC_W  current fetch PC
InstrD  out  INSTR_W  Decode-stage instruction
ValidD  out  1  Decode holds a real instruction
RA1D, RA2D, WA3D  in  RA_W each  decoded register addresses
RegWriteD, MemtoRegD, MemWriteD, PCSrcD, BranchD  in  1 each  decoded controls
CondExE  in  1  condition-check result for the Execute instruction
RA1E, RA2E, WA3E  out  RA_W each  Execute addresses
RegWriteE, MemtoRegE, MemWriteE, PCSrcE, BranchE, ValidE  out  1 each
BranchTakenE  out  1  BranchE & CondExE & ValidE (combinational)
WA3M, WA3W  out  RA_W  Memory and Writeback destinations
RegWriteM, MemtoRegM, MemWriteM, PCSrcM, ValidM  out  1 each
RegWriteW, MemtoRegW, PCSrcW, ValidW  out  1 each

Behaviour:
- Reset: every output register is 0, including PCF=0, InstrD=0 and all Valid*=0. Reset overrides every other input.
- F register: PCF<=PCNextF when !StallF; otherwise PCF holds.
- D register priority is reset > FlushD > StallD > load.
  - FlushD: InstrD=0, ValidD=0.
  - StallD: InstrD and ValidD hold.
  - Load: InstrD<=InstrF, ValidD<=1.
  - FlushD and StallD asserted together means flush.
- E register priority is reset > FlushE > load. There is no E stall.
  - FlushE: all E controls=0, ValidE=0, RA1E/RA2E/WA3E=0.
  - Load: copy the D fields. ValidE<=ValidD.
  - Every D control is ANDed with ValidD on load, so a bubble never writes.
- M register: always loads.
  - RegWriteM<=RegWriteE&CondExE; MemWriteM<=MemWriteE&CondExE; PCSrcM<=PCSrcE&CondExE.
  - MemtoRegM<=MemtoRegE; WA3M<=WA3E; ValidM<=ValidE.
- W register: always loads a straight copy of M: RegWriteW, MemtoRegW, PCSrcW, WA3W, ValidW.
- Latency: a field presented at D appears at E next cycle, at M after 2 cycles and at W after 3, unless flushed.
- Stall of D with no FlushE: E receives a duplicate of the held instruction. The hazard unit always pairs StallD with FlushE. The block does not check this pairing.
- Bubbles carry RA*=0. A spurious ForwardAE match against WA3M=0 is harmless because the bubble is discarded.
- Reset mid-stream: all in-flight instructions are dropped within the same cycle, and the first valid W occurs 4 cycles after release.

Optional Feature:
Macro PIPE_CTRL_PERF_EN.
- Defined: adds outputs StallCnt[31:0], FlushCnt[31:0] and RetireCnt[31:0].
  - StallCnt increments on StallD.
  - FlushCnt increments on FlushD|FlushE, at most once per cycle.
  - RetireCnt increments on ValidW.
  - All three saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: the ports and counters do not exist, and there is no logic or timing impact.

Decomposition:
- Package pipe_pkg:
  - typedef ctrl_t, a struct of RegWrite, MemtoReg, MemWrite, PCSrc, Branch and Valid.
  - typedef regaddr_t, logic[3:0].
  - localparam NOP_INSTR=0.
- One natural sub-module: pipe_stage_reg, a generic flop with enable and synchronous clear.
  - Instantiated per stage with en=!StallX and clr=FlushX.

Test Plan:
- Straight flow: inject WA3D=5 with RegWriteD=1 at cycle 0 and no stalls -> WA3E=5 at cycle 1, WA3M=5 with RegWriteM=1 at cycle 2 (CondExE=1), WA3W=5 with RegWriteW=1 at cycle 3.
- Load-use: StallF=StallD=FlushE=1 for one cycle with InstrF=0xE5901000 -> PCF and InstrD hold; ValidE=0 and RegWriteE=0 next cycle; the held instruction enters E one cycle later.
- Branch taken: BranchE=1, CondExE=1, ValidE=1 -> BranchTakenE=1 combinationally. With FlushD=FlushE=1 next edge -> ValidD=0 and ValidE=0.
- Condition fail: RegWriteE=1, MemWriteE=1, CondExE=0 -> RegWriteM=0 and MemWriteM=0, while ValidM follows ValidE.
- FlushD and StallD together with InstrF=0x12345678 -> InstrD=0 and ValidD=0 (flush wins).
- Reset mid-stream: assert reset with all stages valid -> next cycle every output is 0. With PIPE_CTRL_PERF_EN, 3 stall cycles give StallCnt=3, and StallCnt=0 after reset.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline control-register bank.
package pipe_pkg;

  typedef logic [3:0] regaddr_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
    logic pc_src;
    logic branch;
    logic valid;
  } ctrl_t;

  localparam int unsigned NOP_INSTR = 0;

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic pipeline register: synchronous reset, then synchronous clear, then enable.
module pipe_stage_reg #(
  parameter int unsigned W       = 1,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)    q <= '0;
    else if (clr) q <= CLR_VAL;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/pipe_ctrl_regs.sv
// F/D/E/M/W control-register bank driven by hazard-unit stall/flush commands.
// Optional performance counters: define PIPE_CTRL_PERF_EN.
module pipe_ctrl_regs
  import pipe_pkg::*;
#(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned RA_W    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               StallF,
  input  logic               StallD,
  input  logic               FlushD,
  input  logic               FlushE,
  input  logic [PC_W-1:0]    PCNextF,
  input  logic [INSTR_W-1:0] InstrF,
  output logic [PC_W-1:0]    PCF,
  output logic [INSTR_W-1:0] InstrD,
  output logic               ValidD,
  input  logic [RA_W-1:0]    RA1D,
  input  logic [RA_W-1:0]    RA2D,
  input  logic [RA_W-1:0]    WA3D,
  input  logic               RegWriteD,
  input  logic               MemtoRegD,
  input  logic               MemWriteD,
  input  logic               PCSrcD,
  input  logic               BranchD,
  input  logic               CondExE,
  output logic [RA_W-1:0]    RA1E,
  output logic [RA_W-1:0]    RA2E,
  output logic [RA_W-1:0]    WA3E,
  output logic               RegWriteE,
  output logic               MemtoRegE,
  output logic               MemWriteE,
  output logic               PCSrcE,
  output logic               BranchE,
  output logic               ValidE,
  output logic               BranchTakenE,
  output logic [RA_W-1:0]    WA3M,
  output logic [RA_W-1:0]    WA3W,
  output logic               RegWriteM,
  output logic               MemtoRegM,
  output logic               MemWriteM,
  output logic               PCSrcM,
  output logic               ValidM,
  output logic               RegWriteW,
  output logic               MemtoRegW,
  output logic               PCSrcW,
  output logic               ValidW
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]        StallCnt,
  output logic [31:0]        FlushCnt,
  output logic [31:0]        RetireCnt
`endif
);

  localparam int unsigned E_W = $bits(ctrl_t) + 3 * RA_W;
  localparam int unsigned M_W = 5 + RA_W;
  localparam int unsigned W_W = 4 + RA_W;

  ctrl_t            ctrl_d, ctrl_e;
  logic [E_W-1:0]   e_d, e_q;
  logic [M_W-1:0]   m_d, m_q;
  logic [W_W-1:0]   w_d, w_q;

  // F stage
  pipe_stage_reg #(.W(PC_W)) u_f (
    .clk(clk), .reset(reset), .en(!StallF), .clr(1'b0),
    .d(PCNextF), .q(PCF)
  );

  // D stage: flush loads a NOP bubble
  pipe_stage_reg #(
    .W(INSTR_W + 1),
    .CLR_VAL({INSTR_W'(NOP_INSTR), 1'b0})
  ) u_d (
    .clk(clk), .reset(reset), .en(!StallD), .clr(FlushD),
    .d({InstrF, 1'b1}), .q({InstrD, ValidD})
  );

  // Controls are gated by ValidD so a bubble can never write
  always_comb begin
    ctrl_d            = '0;
    ctrl_d.reg_write  = RegWriteD & ValidD;
    ctrl_d.mem_to_reg = MemtoRegD & ValidD;
    ctrl_d.mem_write  = MemWriteD & ValidD;
    ctrl_d.pc_src     = PCSrcD    & ValidD;
    ctrl_d.branch     = BranchD   & ValidD;
    ctrl_d.valid      = ValidD;
  end

  assign e_d = {ctrl_d, RA1D, RA2D, WA3D};

  pipe_stage_reg #(.W(E_W)) u_e (
    .clk(clk), .reset(reset), .en(1'b1), .clr(FlushE),
    .d(e_d), .q(e_q)
  );

  assign {ctrl_e, RA1E, RA2E, WA3E} = e_q;
  assign RegWriteE = ctrl_e.reg_write;
  assign MemtoRegE = ctrl_e.mem_to_reg;
  assign MemWriteE = ctrl_e.mem_write;
  assign PCSrcE    = ctrl_e.pc_src;
  assign BranchE   = ctrl_e.branch;
  assign ValidE    = ctrl_e.valid;

  assign BranchTakenE = BranchE & CondExE & ValidE;

  // M stage: side-effecting controls are squashed when the condition fails
  assign m_d = {RegWriteE & CondExE, MemtoRegE, MemWriteE & CondExE,
                PCSrcE & CondExE, ValidE, WA3E};

  pipe_stage_reg #(.W(M_W)) u_m (
    .clk(clk), .reset(reset), .en(1'b1), .clr(1'b0),
    .d(m_d), .q(m_q)
  );

  assign {RegWriteM, MemtoRegM, MemWriteM, PCSrcM, ValidM, WA3M} = m_q;

  assign w_d = {RegWriteM, MemtoRegM, PCSrcM, ValidM, WA3M};

  pipe_stage_reg #(.W(W_W)) u_w (
    .clk(clk), .reset(reset), .en(1'b1), .clr(1'b0),
    .d(w_d), .q(w_q)
  );

  assign {RegWriteW, MemtoRegW, PCSrcW, ValidW, WA3W} = w_q;

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      StallCnt  <= '0;
      FlushCnt  <= '0;
      RetireCnt <= '0;
    end else begin
      if (StallD && StallCnt != '1)            StallCnt  <= StallCnt + 32'd1;
      if ((FlushD || FlushE) && FlushCnt != '1) FlushCnt  <= FlushCnt + 32'd1;
      if (ValidW && RetireCnt != '1)           RetireCnt <= RetireCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl_regs.sv
// Directed self-checking bench for pipe_ctrl_regs.
module tb_pipe_ctrl_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF, StallD, FlushD, FlushE;
  logic [31:0] PCNextF, InstrF;
  logic [31:0] PCF, InstrD;
  logic        ValidD;
  logic [3:0]  RA1D, RA2D, WA3D;
  logic        RegWriteD, MemtoRegD, MemWriteD, PCSrcD, BranchD, CondExE;
  logic [3:0]  RA1E, RA2E, WA3E;
  logic        RegWriteE, MemtoRegE, MemWriteE, PCSrcE, BranchE, ValidE, BranchTakenE;
  logic [3:0]  WA3M, WA3W;
  logic        RegWriteM, MemtoRegM, MemWriteM, PCSrcM, ValidM;
  logic        RegWriteW, MemtoRegW, PCSrcW, ValidW;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] StallCnt, FlushCnt, RetireCnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl_regs #(.INSTR_W(32), .PC_W(32), .RA_W(4)) dut (
    .clk(clk), .reset(reset),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .PCNextF(PCNextF), .InstrF(InstrF),
    .PCF(PCF), .InstrD(InstrD), .ValidD(ValidD),
    .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .PCSrcD(PCSrcD), .BranchD(BranchD), .CondExE(CondExE),
    .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .PCSrcE(PCSrcE), .BranchE(BranchE), .ValidE(ValidE),
    .BranchTakenE(BranchTakenE),
    .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .PCSrcM(PCSrcM), .ValidM(ValidM),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .PCSrcW(PCSrcW), .ValidW(ValidW)
`ifdef PIPE_CTRL_PERF_EN
    , .StallCnt(StallCnt), .FlushCnt(FlushCnt), .RetireCnt(RetireCnt)
`endif
  );

  function automatic logic [95:0] all_outs();
    return {PCF, InstrD, ValidD, RA1E, RA2E, WA3E,
            RegWriteE, MemtoRegE, MemWriteE, PCSrcE, BranchE, ValidE, BranchTakenE,
            WA3M, WA3W, RegWriteM, MemtoRegM, MemWriteM, PCSrcM, ValidM,
            RegWriteW, MemtoRegW, PCSrcW, ValidW};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    StallF = 0; StallD = 0; FlushD = 0; FlushE = 0;
    PCNextF = '0; InstrF = '0;
    RA1D = '0; RA2D = '0; WA3D = '0;
    RegWriteD = 0; MemtoRegD = 0; MemWriteD = 0; PCSrcD = 0; BranchD = 0;
    CondExE = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    StallF = 0; StallD = 0; FlushD = 0; FlushE = 0;
    PCNextF = 32'hCAFE_0000; InstrF = 32'hFFFF_FFFF;
    RA1D = 4'hF; RA2D = 4'hF; WA3D = 4'hF;
    RegWriteD = 1; MemtoRegD = 1; MemWriteD = 1; PCSrcD = 1; BranchD = 1;
    CondExE = 1;
    step(); step();
    checks++;
    if (all_outs() !== '0) begin
      errors++; $display("FAIL reset_all got %h exp 0", all_outs());
    end
    checks++;
    if (PCF !== 32'h0) begin errors++; $display("FAIL reset_pcf got %h exp 0", PCF); end
    reset = 0;
    drive_idle();
  endtask

  task automatic test_straight();
    PCNextF = 32'h100; InstrF = 32'hE081_1002;
    step();
    checks++;
    if (PCF !== 32'h100) begin errors++; $display("FAIL str_pcf got %h exp 100", PCF); end
    checks++;
    if ({InstrD, ValidD} !== {32'hE081_1002, 1'b1}) begin
      errors++; $display("FAIL str_instrd got %h/%b exp e0811002/1", InstrD, ValidD);
    end
    WA3D = 4'd5; RegWriteD = 1; CondExE = 1;
    step();
    checks++;
    if ({WA3E, RegWriteE, ValidE} !== {4'd5, 1'b1, 1'b1}) begin
      errors++; $display("FAIL str_e got %h/%b/%b exp 5/1/1", WA3E, RegWriteE, ValidE);
    end
    WA3D = 0; RegWriteD = 0;
    step();
    checks++;
    if ({WA3M, RegWriteM, ValidM} !== {4'd5, 1'b1, 1'b1}) begin
      errors++; $display("FAIL str_m got %h/%b/%b exp 5/1/1", WA3M, RegWriteM, ValidM);
    end
    step();
    checks++;
    if ({WA3W, RegWriteW, ValidW} !== {4'd5, 1'b1, 1'b1}) begin
      errors++; $display("FAIL str_w got %h/%b/%b exp 5/1/1", WA3W, RegWriteW, ValidW);
    end
    drive_idle();
  endtask

  task automatic test_load_use();
    InstrF = 32'hE590_1000; PCNextF = 32'h200;
    step();
    StallF = 1; StallD = 1; FlushE = 1;
    InstrF = 32'hDEAD_BEEF; PCNextF = 32'h204; RegWriteD = 1; WA3D = 4'd1;
    step();
    checks++;
    if ({PCF, InstrD} !== {32'h200, 32'hE590_1000}) begin
      errors++; $display("FAIL lu_hold got %h/%h exp 200/e5901000", PCF, InstrD);
    end
    checks++;
    if ({ValidE, RegWriteE} !== 2'b00) begin
      errors++; $display("FAIL lu_bubble got %b%b exp 00", ValidE, RegWriteE);
    end
    StallF = 0; StallD = 0; FlushE = 0;
    step();
    checks++;
    if ({ValidE, RegWriteE, WA3E} !== {1'b1, 1'b1, 4'd1}) begin
      errors++; $display("FAIL lu_enter got %b/%b/%h exp 1/1/1", ValidE, RegWriteE, WA3E);
    end
    checks++;
    if ({PCF, InstrD} !== {32'h204, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL lu_resume got %h/%h exp 204/deadbeef", PCF, InstrD);
    end
    drive_idle();
  endtask

  task automatic test_branch();
    step();
    BranchD = 1;
    step();
    BranchD = 0;
    CondExE = 1; #1;
    checks++;
    if (BranchTakenE !== 1'b1) begin
      errors++; $display("FAIL br_taken got %b exp 1", BranchTakenE);
    end
    CondExE = 0; #1;
    checks++;
    if (BranchTakenE !== 1'b0) begin
      errors++; $display("FAIL br_notcond got %b exp 0", BranchTakenE);
    end
    CondExE = 1; FlushD = 1; FlushE = 1;
    step();
    checks++;
    if ({ValidD, ValidE, BranchE, BranchTakenE} !== 4'b0000) begin
      errors++; $display("FAIL br_flush got %b%b%b%b exp 0000", ValidD, ValidE, BranchE, BranchTakenE);
    end
    drive_idle();
  endtask

  task automatic test_cond_fail();
    step();
    RegWriteD = 1; MemWriteD = 1; PCSrcD = 1; MemtoRegD = 1; WA3D = 4'd9;
    step();
    drive_idle();
    CondExE = 0;
    step();
    checks++;
    if ({RegWriteM, MemWriteM, PCSrcM, MemtoRegM, ValidM, WA3M} !== {5'b00011, 4'd9}) begin
      errors++; $display("FAIL cond_fail got %b%b%b%b%b/%h exp 00011/9",
                         RegWriteM, MemWriteM, PCSrcM, MemtoRegM, ValidM, WA3M);
    end
    drive_idle();
  endtask

  task automatic test_flush_stall();
    InstrF = 32'h1111_1111;
    step();
    InstrF = 32'h1234_5678; FlushD = 1; StallD = 1;
    step();
    checks++;
    if ({InstrD, ValidD} !== 33'h0) begin
      errors++; $display("FAIL flush_wins got %h/%b exp 0/0", InstrD, ValidD);
    end
    drive_idle();
  endtask

  task automatic test_reset_mid();
    WA3D = 4'd7; RegWriteD = 1; CondExE = 1; PCNextF = 32'h300; InstrF = 32'hE000_0000;
    repeat (4) step();
    checks++;
    if ({ValidD, ValidE, ValidM, ValidW} !== 4'b1111) begin
      errors++; $display("FAIL mid_full got %b%b%b%b exp 1111", ValidD, ValidE, ValidM, ValidW);
    end
    reset = 1;
    step();
    checks++;
    if (all_outs() !== '0) begin
      errors++; $display("FAIL mid_reset got %h exp 0", all_outs());
    end
    reset = 0;
    repeat (3) step();
    checks++;
    if ({ValidM, ValidW} !== 2'b10) begin
      errors++; $display("FAIL mid_rel3 got %b%b exp 10", ValidM, ValidW);
    end
    step();
    checks++;
    if ({ValidW, RegWriteW, WA3W} !== {1'b1, 1'b1, 4'd7}) begin
      errors++; $display("FAIL mid_rel4 got %b/%b/%h exp 1/1/7", ValidW, RegWriteW, WA3W);
    end
    drive_idle();
  endtask

`ifdef PIPE_CTRL_PERF_EN
  task automatic test_perf();
    reset = 1;
    step();
    reset = 0;
    StallF = 1; StallD = 1; FlushD = 1; FlushE = 1;
    repeat (3) step();
    drive_idle();
    checks++;
    if ({StallCnt, FlushCnt, RetireCnt} !== {32'd3, 32'd3, 32'd0}) begin
      errors++; $display("FAIL perf_cnt got %0d/%0d/%0d exp 3/3/0", StallCnt, FlushCnt, RetireCnt);
    end
    reset = 1;
    step();
    reset = 0;
    checks++;
    if ({StallCnt, FlushCnt, RetireCnt} !== 96'h0) begin
      errors++; $display("FAIL perf_clr got %0d/%0d/%0d exp 0/0/0", StallCnt, FlushCnt, RetireCnt);
    end
  endtask
`endif

  initial begin
    drive_idle();
    reset = 1;
    test_reset();
    test_straight();
    test_load_use();
    test_branch();
    test_cond_fail();
    test_flush_stall();
    test_reset_mid();
`ifdef PIPE_CTRL_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
